// File: rtl/cordic_angle_prep_if.sv
// Handshake and output bundle between the angle front-end and its neighbours.
// The upstream drives in_valid/angle_deg; the block answers with in_ready and the CORDIC inputs.
interface cordic_angle_prep_if;
    // valid/ready: a transfer happens on a rising edge where in_valid and in_ready are
    // both high; while in_ready is low the upstream holds in_valid and angle_deg unchanged.
    logic       in_valid;
    logic       in_ready;
    logic [8:0] angle_deg;
    logic       out_valid;
    logic       frame_start;
    logic [7:0] xin;
    logic [7:0] yin;
    logic [7:0] angle;

    modport master (
        output in_valid, angle_deg,
        input  in_ready, out_valid, frame_start, xin, yin, angle
    );

    modport slave (
        input  in_valid, angle_deg,
        output in_ready, out_valid, frame_start, xin, yin, angle
    );
endinterface

// File: rtl/cordic_angle_prep.sv
// Angle front-end for the 8-bit CORDIC sine rotator: reduces degrees mod 360, folds into
// [-90,+90], converts to 2.6 radians and holds xin/yin/angle for one CORDIC frame.
module cordic_angle_prep #(
    parameter int HOLD_CYCLES = 9,
    parameter int GAIN_X      = 39,
    parameter int DEG2RAD_MUL = 286
) (
    input  logic                  clk,
    input  logic                  rst,
    cordic_angle_prep_if.slave    bus,
    output logic [2:0]            o_dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REDUCE = 3'd1,
        S_FOLD   = 3'd2,
        S_SCALE  = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    localparam int                CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic signed [16:0] MUL     = 17'(DEG2RAD_MUL);

    state_t                  r_state;
    state_t                  w_next;
    logic                    w_accept;
    logic [8:0]              r_deg;
    logic [8:0]              r_d;
    logic [8:0]              w_d;
    logic signed [9:0]       w_d10;
    logic signed [9:0]       w_z;
    logic signed [9:0]       r_z;
    logic signed [16:0]      w_z17;
    logic signed [16:0]      w_p;
    logic signed [16:0]      w_q;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_frame_start;
    logic [7:0]              r_xin;
    logic [7:0]              r_yin;
    logic [7:0]              r_angle;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.in_valid) w_next = S_REDUCE;
            S_REDUCE: w_next = S_FOLD;
            S_FOLD:   w_next = S_SCALE;
            S_SCALE:  w_next = S_HOLD;
            S_HOLD:   if (r_cnt == '0) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    assign w_accept     = bus.in_valid && (r_state == S_IDLE);
    assign bus.in_ready = (r_state == S_IDLE);
    assign o_dbg_state  = r_state;

    // A single subtraction is enough because the input never reaches 720.
    assign w_d   = (r_deg >= 9'd360) ? (r_deg - 9'd360) : r_deg;
    assign w_d10 = signed'({1'b0, r_d});

    always_comb begin
        w_z = w_d10;
        if (r_d <= 9'd90) begin
            w_z = w_d10;
        end else if (r_d <= 9'd269) begin
            w_z = 10'sd180 - w_d10;
        end else begin
            w_z = w_d10 - 10'sd360;
        end
    end

    // Round-half-up via +128 then floor shift; |z|<=90 keeps the result within +-101.
    assign w_z17 = 17'(r_z);
    assign w_p   = w_z17 * MUL;
    assign w_q   = (w_p + 17'sd128) >>> 8;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_deg         <= '0;
            r_d           <= '0;
            r_z           <= '0;
            r_cnt         <= '0;
            r_frame_start <= 1'b0;
            r_xin         <= '0;
            r_yin         <= '0;
            r_angle       <= '0;
        end else begin
            r_frame_start <= 1'b0;
            if (w_accept) begin
                r_deg <= bus.angle_deg;
            end
            if (r_state == S_REDUCE) begin
                r_d <= w_d;
            end
            if (r_state == S_FOLD) begin
                r_z <= w_z;
            end
            // Outputs are only written on HOLD entry so they stay put after the frame.
            if (r_state == S_SCALE) begin
                r_xin         <= 8'(GAIN_X);
                r_yin         <= 8'd0;
                r_angle       <= 8'(w_q);
                r_cnt         <= CNT_LOAD;
                r_frame_start <= 1'b1;
            end else if ((r_state == S_HOLD) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign bus.out_valid   = (r_state == S_HOLD);
    assign bus.frame_start = r_frame_start;
    assign bus.xin         = r_xin;
    assign bus.yin         = r_yin;
    assign bus.angle       = r_angle;
endmodule

// File: tb/tb_cordic_angle_prep.sv
// Directed bench for cordic_angle_prep: reset, abort, fold/modulo angles and back-to-back
// frames, with expected angles queued at accept time and popped at frame start.
module tb_cordic_angle_prep;
    localparam int         HOLD = 9;
    localparam logic [7:0] GAIN = 8'd39;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] dbg_state;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];

    cordic_angle_prep_if bus_if ();

    cordic_angle_prep #(
        .HOLD_CYCLES (HOLD),
        .GAIN_X      (39),
        .DEG2RAD_MUL (286)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_angle(input int deg);
        int  d;
        int  z;
        real r;
        d = deg % 360;
        if (d <= 90)      z = d;
        else if (d < 270) z = 180 - d;
        else              z = d - 360;
        r = real'(z) * (286.0 / 256.0) + 0.5;
        return 8'(int'($floor(r)));
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [8:0] deg);
        @(negedge clk);
        bus_if.in_valid  = 1'b1;
        bus_if.angle_deg = deg;
        exp_q.push_back(model_angle(int'(deg)));
        chk("in_ready_before_accept", 16'(bus_if.in_ready), 16'd1);
        @(posedge clk);
    endtask

    // Called right after the accepting edge; ends on the first IDLE cycle's negedge.
    task automatic follow_frame(input logic hold_valid, input logic [8:0] next_deg);
        logic [7:0] e;
        @(negedge clk);
        if (hold_valid) bus_if.angle_deg = next_deg;
        else            bus_if.in_valid  = 1'b0;
        chk("busy_in_ready", 16'(bus_if.in_ready), 16'd0);
        chk("pre_out_valid", 16'(bus_if.out_valid), 16'd0);
        repeat (2) begin
            @(negedge clk);
            chk("pre_out_valid", 16'(bus_if.out_valid), 16'd0);
        end
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        chk("first_out_valid", 16'(bus_if.out_valid), 16'd1);
        chk("frame_start", 16'(bus_if.frame_start), 16'd1);
        chk("angle", 16'(bus_if.angle), 16'(e));
        chk("xin", 16'(bus_if.xin), 16'(GAIN));
        chk("yin", 16'(bus_if.yin), 16'd0);
        for (int k = 1; k < HOLD; k++) begin
            @(negedge clk);
            chk("hold_out_valid", 16'(bus_if.out_valid), 16'd1);
            chk("hold_frame_start", 16'(bus_if.frame_start), 16'd0);
            chk("hold_angle", 16'(bus_if.angle), 16'(e));
            chk("hold_xin", 16'(bus_if.xin), 16'(GAIN));
            chk("hold_in_ready", 16'(bus_if.in_ready), 16'd0);
        end
        @(negedge clk);
        chk("post_out_valid", 16'(bus_if.out_valid), 16'd0);
        chk("post_in_ready", 16'(bus_if.in_ready), 16'd1);
        chk("post_angle_kept", 16'(bus_if.angle), 16'(e));
        chk("post_xin_kept", 16'(bus_if.xin), 16'(GAIN));
    endtask

    initial begin
        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.angle_deg = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 16'(bus_if.in_ready), 16'd1);
        chk("rst_out_valid", 16'(bus_if.out_valid), 16'd0);
        chk("rst_frame_start", 16'(bus_if.frame_start), 16'd0);
        chk("rst_xin", 16'(bus_if.xin), 16'd0);
        chk("rst_yin", 16'(bus_if.yin), 16'd0);
        chk("rst_angle", 16'(bus_if.angle), 16'd0);

        // Abort: reset two cycles after accept discards the angle in flight.
        bus_if.in_valid  = 1'b1;
        bus_if.angle_deg = 9'd30;
        @(posedge clk);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", 16'(bus_if.in_ready), 16'd1);
        for (int k = 0; k < HOLD + 4; k++) begin
            @(negedge clk);
            chk("abort_out_valid", 16'(bus_if.out_valid), 16'd0);
            chk("abort_frame_start", 16'(bus_if.frame_start), 16'd0);
            chk("abort_angle", 16'(bus_if.angle), 16'd0);
            chk("abort_xin", 16'(bus_if.xin), 16'd0);
        end

        accept(9'd30);  follow_frame(1'b0, 9'd0);
        accept(9'd150); follow_frame(1'b0, 9'd0);
        accept(9'd210); follow_frame(1'b0, 9'd0);
        accept(9'd90);  follow_frame(1'b0, 9'd0);
        accept(9'd270); follow_frame(1'b0, 9'd0);
        accept(9'd0);   follow_frame(1'b0, 9'd0);
        accept(9'd359); follow_frame(1'b0, 9'd0);
        accept(9'd400); follow_frame(1'b0, 9'd0);
        accept(9'd511); follow_frame(1'b0, 9'd0);
        accept(9'd91);  follow_frame(1'b0, 9'd0);
        accept(9'd269); follow_frame(1'b0, 9'd0);
        accept(9'd360); follow_frame(1'b0, 9'd0);
        accept(9'(100 + $urandom_range(0, 300))); follow_frame(1'b0, 9'd0);

        // Back-to-back: in_valid stays high, second angle is taken in the first IDLE cycle.
        accept(9'd30);
        follow_frame(1'b1, 9'd210);
        exp_q.push_back(model_angle(210));
        @(posedge clk);
        follow_frame(1'b0, 9'd0);

        chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
